disp_ch_scheduler: RTL
======================

// Module: disp_ch_scheduler
// PURPOSE
//   Sequencer for the 8-channel 32-bit display multiplexer. Drives its channel
//   select (Test[2:0]) and its channel-0 latch enable (EN). Supports manual select
//   from switches, or timed auto-scan over a channel mask.
//   Also runs a 4-phase req/ack handshake so the CPU can strobe a new channel-0
//   snapshot (Data0/LES/point) into the mux latch.
// PARAMETERS
//   DWELL_CYC  25_000_000  clk cycles each channel is shown in auto-scan (>=2)
//   CNT_W      25          dwell counter width; 2**CNT_W >= DWELL_CYC
// PORTS
//   clk         input   1  system clock, all state on rising edge
//   rst         input   1  asynchronous, active-low reset
//   auto_en     input   1  1 = auto-scan mode, 0 = manual mode
//   sw_sel      input   3  manual channel select
//   ch_mask     input   8  auto-scan enables; bit0 ignored (ch0 always enabled)
//   hold        input   1  freeze dwell counter in auto-scan
//   cpu_wr_req  input   1  CPU latch request, 4-phase level
//   cpu_wr_ack  output  1  latch acknowledge, 4-phase level
//   Test        output  3  channel select to display mux
//   EN          output  1  one-cycle latch strobe for channel 0
//   ch_change   output  1  one-cycle pulse on the cycle Test takes a new value
// BEHAVIOUR
//   Reset (rst=0, async): Test=0, EN=0, cpu_wr_ack=0, ch_change=0, cnt=0,
//     mode FSM=S_MANUAL, latch FSM=L_IDLE. All outputs are registered.
//   Mode FSM, evaluated every clk:
//   - S_MANUAL: Test <= sw_sel (1-cycle latency). auto_en=1 -> S_SCAN.
//   - S_MANUAL -> S_SCAN entry: cnt <= 0; Test keeps its current value.
//   - S_SCAN: if hold=1, cnt frozen. Otherwise cnt++ each cycle.
//   - S_SCAN at cnt==DWELL_CYC-1 (not held): cnt <= 0 and
//     Test <= next enabled channel after Test.
//   - Next-channel search is circular (7 wraps to 0), using eff_mask = ch_mask|8'h01.
//   - Only Test itself enabled: Test unchanged, no ch_change.
//   - Current Test masked off: it still dwells its full period, then advances.
//   - S_SCAN: auto_en=0 -> S_MANUAL. Test <= sw_sel on that same edge; cnt <= 0.
//   - ch_change=1 for exactly the cycle after any edge where Test's new value
//     differs from its old value. This covers manual, scan and mode-switch edges.
//   - ch_mask and sw_sel are sampled only at the edge that uses them; no glitching.
//   Latch FSM (independent of mode FSM and hold):
//   - L_IDLE: cpu_wr_req=1 -> L_STROBE.
//   - L_STROBE: EN=1 for exactly this one cycle. Next state is L_ACK.
//   - L_ACK: cpu_wr_ack=1, held until cpu_wr_req=0. On the edge after req falls,
//     ack <= 0 and FSM returns to L_IDLE.
//   - Timing: req rise at edge k -> EN=1 after edge k+1 -> ack=1 after edge k+2.
//   - req held high after ack: no further EN. A new EN needs req low, then high again.
//   - req dropping during L_STROBE: EN still completes, then ack=1 for one cycle,
//     then idle.
//   - EN never asserts outside L_STROBE. Latch FSM ignores channel changes, and
//     channel changes ignore the latch FSM.
//   Reset mid-operation: abort any dwell or handshake. ack drops immediately; no EN.
// TESTING (DWELL_CYC=4 in bench)
//   1 Reset: hold rst=0 with req=1 and auto_en=1 -> Test=0, EN=0, ack=0,
//     ch_change=0. After release, first EN appears 2 edges later.
//   2 Manual: auto_en=0, sw_sel 0->5 -> Test=5 one edge later, ch_change single
//     pulse. sw_sel stays 5 -> no further pulses.
//   3 Scan: mask=8'b1010_0100, Test=0 -> sequence 0,2,5,7,0,...
//     Each value lasts 4 clk; ch_change pulses once per step.
//   4 Scan edge cases:
//     - mask=8'h00 -> Test stays 0, no ch_change.
//     - hold=1 for 10 clk mid-dwell -> step delayed by exactly 10 clk.
//   5 Handshake: req rise -> EN single pulse, then ack=1 held while req=1
//     (20 clk, one EN total); req=0 -> ack=0 next edge. Run it during a scan step,
//     and separately assert rst in L_ACK -> ack=0 asynchronously.
//   6 Mode switch: scanning at Test=5, sw_sel=1, auto_en 1->0 -> Test=1 next edge,
//     ch_change pulse. Re-enable -> dwell restarts from cnt=0.

Source files
------------

// File: rtl/disp_ch_scheduler.sv
// disp_ch_scheduler
//   Channel sequencer for the 8-channel display multiplexer. A mode FSM picks the
//   mux channel (Test), either straight from the switches or by timed auto-scan
//   over a channel mask. A separate latch FSM runs a 4-phase req/ack handshake
//   that fires a single-cycle EN strobe into the channel-0 latch.
//
//   state     | meaning
//   S_MANUAL  | Test follows sw_sel with one cycle of latency
//   S_SCAN    | Test steps through enabled channels, DWELL_CYC cycles each
//   L_IDLE    | waiting for cpu_wr_req
//   L_STROBE  | EN high for this single cycle
//   L_ACK     | cpu_wr_ack high until cpu_wr_req drops
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   auto_en    1 = auto-scan, 0 = manual
//   sw_sel     manual channel select
//   ch_mask    auto-scan channel enables (bit 0 forced on)
//   hold       freezes the dwell counter while scanning
//   cpu_wr_req 4-phase request from the CPU
//   cpu_wr_ack 4-phase acknowledge to the CPU
//   Test       channel select to the display mux
//   EN         one-cycle channel-0 latch strobe
//   ch_change  one-cycle pulse when Test has just changed
module disp_ch_scheduler #(
  parameter int DWELL_CYC = 25_000_000,
  parameter int CNT_W     = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_en,
  input  logic [2:0] sw_sel,
  input  logic [7:0] ch_mask,
  input  logic       hold,
  input  logic       cpu_wr_req,
  output logic       cpu_wr_ack,
  output logic [2:0] Test,
  output logic       EN,
  output logic       ch_change
);

  localparam logic       S_MANUAL = 1'b0;
  localparam logic       S_SCAN   = 1'b1;

  localparam logic [1:0] L_IDLE   = 2'd0;
  localparam logic [1:0] L_STROBE = 2'd1;
  localparam logic [1:0] L_ACK    = 2'd2;

  localparam logic [CNT_W-1:0] LP_CNT_TC = CNT_W'(DWELL_CYC - 1);

  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_test;
  logic             r_ch_change;
  logic [1:0]       r_lstate;
  logic             r_en;
  logic             r_ack;

  logic [7:0]       w_eff_mask;
  logic [2:0]       w_next_ch;
  logic [2:0]       w_idx;
  logic             w_found;
  logic             w_mode_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [2:0]       w_test_n;
  logic [1:0]       w_lstate_n;

  assign w_eff_mask = ch_mask | 8'h01;

  // Circular search for the first enabled channel after the current one. Since
  // channel 0 is always enabled, only Test==0 with nothing else enabled finds
  // nothing, in which case Test stays put.
  always_comb begin
    w_next_ch = r_test;
    w_found   = 1'b0;
    w_idx     = 3'd0;
    for (int i = 1; i < 8; i++) begin
      w_idx = r_test + 3'(i);
      if (!w_found && w_eff_mask[w_idx]) begin
        w_next_ch = w_idx;
        w_found   = 1'b1;
      end
    end
  end

  always_comb begin
    w_mode_n = r_mode;
    w_cnt_n  = r_cnt;
    w_test_n = r_test;
    case (r_mode)
      S_MANUAL: begin
        if (auto_en) begin
          // Entering scan: the current channel starts a fresh dwell.
          w_mode_n = S_SCAN;
          w_cnt_n  = '0;
        end else begin
          w_test_n = sw_sel;
        end
      end
      default: begin
        if (!auto_en) begin
          w_mode_n = S_MANUAL;
          w_cnt_n  = '0;
          w_test_n = sw_sel;
        end else if (!hold) begin
          if (r_cnt == LP_CNT_TC) begin
            w_cnt_n  = '0;
            w_test_n = w_next_ch;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_lstate_n = r_lstate;
    case (r_lstate)
      L_IDLE:   if (cpu_wr_req) w_lstate_n = L_STROBE;
      L_STROBE: w_lstate_n = L_ACK;
      L_ACK:    if (!cpu_wr_req) w_lstate_n = L_IDLE;
      default:  w_lstate_n = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode      <= S_MANUAL;
      r_cnt       <= '0;
      r_test      <= 3'd0;
      r_ch_change <= 1'b0;
    end else begin
      r_mode      <= w_mode_n;
      r_cnt       <= w_cnt_n;
      r_test      <= w_test_n;
      r_ch_change <= (w_test_n != r_test);
    end
  end

  // EN and ack are registered decodes of the next latch state so they line up
  // exactly with L_STROBE / L_ACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lstate <= L_IDLE;
      r_en     <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_lstate <= w_lstate_n;
      r_en     <= (w_lstate_n == L_STROBE);
      r_ack    <= (w_lstate_n == L_ACK);
    end
  end

  assign Test       = r_test;
  assign EN         = r_en;
  assign cpu_wr_ack = r_ack;
  assign ch_change  = r_ch_change;

endmodule
